// File: rtl/opl_exp_mixer.sv
// Log-domain to linear converter and channel accumulator for FM operators.
// Define OPL3_ONES_COMPLEMENT_EN for one's-complement negation of negative half-waves.
module opl_exp_mixer #(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [11:0]             in_logsin,
  input  logic                    in_sign,
  input  logic [9:0]              in_env,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample
);

  // Handshake: in_valid marks a sample that is always consumed (no ready);
  // out_valid is a one-cycle pulse and out_sample holds until the next pulse.

  typedef logic [255:0][9:0] exp_tbl_t;

  // EXP[i] = round((2^(i/256) - 1) * 1024), built at elaboration in Q2.62.
  function automatic exp_tbl_t build_exp_tbl();
    exp_tbl_t     tbl;
    logic [127:0] lo;
    logic [127:0] hi;
    logic [127:0] mid;
    logic [127:0] p;
    lo = 128'd1 << 62;
    hi = 128'd1 << 63;
    for (int b = 0; b < 64; b++) begin
      mid = (lo + hi) >> 1;
      p = mid;
      for (int s = 0; s < 8; s++) begin
        p = (p <= (128'd1 << 63)) ? ((p * p) >> 62) : p;
      end
      if (p <= (128'd1 << 63)) lo = mid;
      else                     hi = mid;
    end
    p = 128'd1 << 62;
    for (int i = 0; i < 256; i++) begin
      tbl[i] = 10'(((p - (128'd1 << 62)) * 128'd1024 + (128'd1 << 61)) >> 62);
      p = (p * lo) >> 62;
    end
    return tbl;
  endfunction

  localparam exp_tbl_t EXP = build_exp_tbl();

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  // S1: total attenuation
  logic        s1_valid, s1_first, s1_last, s1_sign;
  logic [13:0] s1_att;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_att   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_sign  <= in_sign;
      s1_att   <= {2'b00, in_logsin} + {1'b0, in_env, 3'b000};
    end
  end

  // S2: fractional part through the exponent ROM
  logic       s2_valid, s2_first, s2_last, s2_sign;
  logic [5:0] s2_ipart;
  logic [9:0] s2_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sign  <= 1'b0;
      s2_ipart <= '0;
      s2_e     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sign  <= s1_sign;
      s2_ipart <= s1_att[13:8];
      s2_e     <= EXP[~s1_att[7:0]];
    end
  end

  // S3: integer part as a right shift, then signed value
  logic [11:0]        mag_full;
  logic [11:0]        mag;
  logic signed [12:0] val_next;

  always_comb begin
    mag_full = {1'b1, s2_e, 1'b0};
    mag      = (s2_ipart >= 6'd12) ? 12'd0 : (mag_full >> s2_ipart);
`ifdef OPL3_ONES_COMPLEMENT_EN
    val_next = s2_sign ? ~{1'b0, mag} : {1'b0, mag};
`else
    val_next = s2_sign ? -{1'b0, mag} : {1'b0, mag};
`endif
  end

  logic               s3_valid, s3_first, s3_last;
  logic signed [12:0] s3_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
      s3_val   <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_first <= s2_first;
      s3_last  <= s2_last;
      s3_val   <= val_next;
    end
  end

  // S4: accumulate; first restarts the sum, last publishes the clamped total
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] val_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] clamped;

  always_comb begin
    val_ext  = {{(ACC_W - 13){s3_val[12]}}, s3_val};
    acc_next = s3_first ? val_ext : (acc + val_ext);
    if (acc_next > SAT_MAX)      clamped = SAT_MAX;
    else if (acc_next < SAT_MIN) clamped = SAT_MIN;
    else                         clamped = acc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= s3_valid & s3_last;
      if (s3_valid) begin
        acc <= acc_next;
        if (s3_last) out_sample <= OUT_W'(clamped);
      end
    end
  end

endmodule
